// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - register map, status bit indices and FSM states for the SPI master
package spi_master_pkg;

    localparam logic [1:0] SPI_DATA   = 2'd0;
    localparam logic [1:0] SPI_STATUS = 2'd1;
    localparam logic [1:0] SPI_CTRL   = 2'd2;
    localparam logic [1:0] SPI_CS     = 2'd3;

    localparam int ST_BUSY     = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_COLL     = 2;

    typedef enum logic {
        IDLE,
        XFER
    } spi_state_t;

endpackage

// File: rtl/spi_master_core.sv
// rtl/spi_master_core.sv - SCK divider, edge counter and shift/sample engine for one byte
module spi_master_core
    import spi_master_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic [7:0] div_i,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic       miso_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rx_byte_o,
    output logic       sck_o,
    output logic       mosi_o
);

    spi_state_t state_q, state_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [3:0] edge_cnt_q, edge_cnt_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       tick;
    logic       odd_edge;
    logic       last_edge;

    assign tick      = (div_cnt_q == div_i);
    assign odd_edge  = ~edge_cnt_q[0];
    assign last_edge = (edge_cnt_q == 4'd15);

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        done_o     = 1'b0;
        case (state_q)
            IDLE: begin
                sck_d = cpol_i;
                if (start_i) begin
                    state_d    = XFER;
                    div_cnt_d  = 8'd0;
                    edge_cnt_d = 4'd0;
                    tx_d       = tx_byte_i;
                    rx_d       = 8'd0;
                    if (!cpha_i) begin
                        mosi_d = tx_byte_i[7];
                    end
                end
            end
            XFER: begin
                if (tick) begin
                    div_cnt_d  = 8'd0;
                    sck_d      = ~sck_q;
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    // CPHA=0 samples on odd edges, CPHA=1 on even edges
                    if (odd_edge != cpha_i) begin
                        rx_d = {rx_q[6:0], miso_i};
                    end else if (cpha_i) begin
                        mosi_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end else if (!last_edge) begin
                        mosi_d = tx_q[6];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    if (last_edge) begin
                        state_d = IDLE;
                        done_o  = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            div_cnt_q  <= 8'd0;
            edge_cnt_q <= 4'd0;
            tx_q       <= 8'd0;
            rx_q       <= 8'd0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
        end
    end

    // With CPHA=1 the final sample lands on edge 16, the same cycle done fires
    assign rx_byte_o = cpha_i ? {rx_q[6:0], miso_i} : rx_q;
    assign busy_o    = (state_q == XFER);
    assign sck_o     = sck_q;
    assign mosi_o    = mosi_q;

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - memory-mapped SPI master: register front end and bus decode
module spi_master
    import spi_master_pkg::*;
#(
    parameter logic [7:0] DEFAULT_DIV = 8'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic        sck_out,
    output logic        mosi_out,
    input  logic        miso_in,
    output logic        cs_n_out
);

    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       coll_q, coll_d;
    logic [7:0] div_q, div_d;
    logic       cpol_q, cpol_d;
    logic       cpha_q, cpha_d;
    logic       cs_n_q, cs_n_d;

    logic       wr;
    logic       rd;
    logic [1:0] reg_sel;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] rx_byte;
    logic       unused_bits;

    assign wr          = sel_in & (|write_mask_in);
    assign rd          = sel_in & read_in;
    assign reg_sel     = address_in[3:2];
    assign start       = wr && (reg_sel == SPI_DATA) && !busy;
    assign unused_bits = ^{address_in[31:4], address_in[1:0], write_value_in[31:10]};

    spi_master_core u_core (
        .clk       (clk),
        .resetn    (reset),
        .start_i   (start),
        .tx_byte_i (write_value_in[7:0]),
        .div_i     (div_q),
        .cpol_i    (cpol_q),
        .cpha_i    (cpha_q),
        .miso_i    (miso_in),
        .busy_o    (busy),
        .done_o    (done),
        .rx_byte_o (rx_byte),
        .sck_o     (sck_out),
        .mosi_o    (mosi_out)
    );

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        coll_d     = coll_q;
        div_d      = div_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        cs_n_d     = cs_n_q;
        if (wr && (reg_sel == SPI_CTRL) && !busy) begin
            {cpha_d, cpol_d, div_d} = write_value_in[9:0];
        end
        if (wr && (reg_sel == SPI_CS)) begin
            cs_n_d = write_value_in[0];
        end
        // A new collision wins over a simultaneous clear
        if (wr && (reg_sel == SPI_STATUS) && write_value_in[ST_COLL]) begin
            coll_d = 1'b0;
        end
        if (wr && (reg_sel == SPI_DATA) && busy) begin
            coll_d = 1'b1;
        end
        if (rd && (reg_sel == SPI_DATA)) begin
            rx_valid_d = 1'b0;
        end
        if (done) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            coll_q     <= 1'b0;
            div_q      <= DEFAULT_DIV;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            coll_q     <= coll_d;
            div_q      <= div_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            cs_n_q     <= cs_n_d;
        end
    end

    always_comb begin
        read_value_out = 32'd0;
        if (sel_in) begin
            case (reg_sel)
                SPI_DATA:   read_value_out = {24'd0, rx_data_q};
                SPI_STATUS: begin
                    read_value_out[ST_BUSY]     = busy;
                    read_value_out[ST_RX_VALID] = rx_valid_q;
                    read_value_out[ST_COLL]     = coll_q;
                end
                SPI_CTRL:   read_value_out = {22'd0, cpha_q, cpol_q, div_q};
                SPI_CS:     read_value_out = {31'd0, cs_n_q};
                default:    read_value_out = 32'd0;
            endcase
        end
    end

    assign ready_out = sel_in;
    assign cs_n_out  = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master with a behavioural SPI slave
module tb_spi_master;
    import spi_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata, rdata;
    logic        sel, rd;
    logic [3:0]  wmask;
    logic        ready, sck, mosi, miso, cs_n;

    always #5 clk = ~clk;

    spi_master #(.DEFAULT_DIV(8'd2)) dut (
        .clk(clk), .reset(rst_n), .address_in(addr), .sel_in(sel), .read_in(rd),
        .read_value_out(rdata), .write_mask_in(wmask), .write_value_in(wdata),
        .ready_out(ready), .sck_out(sck), .mosi_out(mosi), .miso_in(miso), .cs_n_out(cs_n)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Slave/observer model: counts SCK edges, records MOSI on sampling edges, drives MISO MSB first
    int         edges = 0, rises = 0, first_edge_cyc = 0, last_edge_cyc = 0;
    logic [7:0] rec_mosi = 8'd0;
    logic [7:0] slave_byte = 8'd0;
    logic       cfg_cpha = 1'b0, cfg_cpol = 1'b0, loop = 1'b0;

    always @(sck) begin
        edges = edges + 1;
        if (sck === 1'b1) rises = rises + 1;
        if (edges == 1) first_edge_cyc = cyc;
        last_edge_cyc = cyc;
        if ((edges % 2 == 0) == cfg_cpha) rec_mosi = {rec_mosi[6:0], mosi};
    end

    function automatic logic slave_bit(input logic [7:0] b, input int e, input logic cph);
        int idx;
        idx = cph ? 7 - ((e > 0 ? e - 1 : 0) / 2) : 7 - (e / 2);
        if (idx < 0) idx = 0;
        return b[idx];
    endfunction

    assign miso = loop ? mosi : slave_bit(slave_byte, edges, cfg_cpha);

    task automatic bus_write(input logic [1:0] r, input logic [31:0] v);
        @(negedge clk);
        addr = {28'h0009000, r, 2'b00}; wdata = v; wmask = 4'hF; sel = 1'b1; rd = 1'b0;
        @(negedge clk);
        sel = 1'b0; wmask = 4'h0;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] v);
        @(negedge clk);
        addr = {28'h0009000, r, 2'b00}; wmask = 4'h0; sel = 1'b1; rd = 1'b1;
        #1 v = rdata;
        @(negedge clk);
        sel = 1'b0; rd = 1'b0;
    endtask

    task automatic set_ctrl(input logic [7:0] d, input logic pol, input logic pha);
        bus_write(SPI_CTRL, {22'd0, pha, pol, d});
        cfg_cpha = pha; cfg_cpol = pol;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_xfer(input logic [7:0] tx, output int p0);
        edges = 0; rises = 0; rec_mosi = 8'd0;
        bus_write(SPI_DATA, {24'd0, tx});
        p0 = cyc;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            addr = {28'h0009000, SPI_STATUS, 2'b00}; sel = 1'b1; rd = 1'b1; wmask = 4'h0;
            #1;
            if (!rdata[ST_BUSY]) break;
            n++;
            @(negedge clk);
        end
        sel = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        n_cmp++; if (sck !== 1'b0) begin n_err++; $display("FAIL reset_sck got %b want 0", sck); end
        n_cmp++; if (mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi got %b want 0", mosi); end
        n_cmp++; if (cs_n !== 1'b1) begin n_err++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
        @(negedge clk);
        addr = {28'h0009000, SPI_CTRL, 2'b00}; sel = 1'b1; rd = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready); end
        n_cmp++; if (rdata !== 32'd2) begin n_err++; $display("FAIL reset_ctrl got %h want 2", rdata); end
        sel = 1'b0; rd = 1'b0;
        bus_read(SPI_STATUS, v);
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_status got %h want 0", v); end
        bus_read(SPI_DATA, v);
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_data got %h want 0", v); end
    endtask

    task automatic test_mode0_loop();
        int p0, n; logic [31:0] v;
        loop = 1'b1;
        set_ctrl(8'd0, 1'b0, 1'b0);
        start_xfer(8'hA5, p0);
        wait_done(n);
        n_cmp++; if (n != 16) begin n_err++; $display("FAIL m0_busy got %0d want 16", n); end
        n_cmp++; if (rises != 8) begin n_err++; $display("FAIL m0_rises got %0d want 8", rises); end
        n_cmp++; if (rec_mosi !== 8'hA5) begin n_err++; $display("FAIL m0_mosi got %h want a5", rec_mosi); end
        n_cmp++; if (last_edge_cyc - p0 != 16) begin n_err++; $display("FAIL m0_last_edge got %0d want 16", last_edge_cyc - p0); end
        bus_read(SPI_DATA, v);
        n_cmp++; if (v !== 32'hA5) begin n_err++; $display("FAIL m0_data got %h want a5", v); end
        bus_read(SPI_STATUS, v);
        n_cmp++; if (v[ST_RX_VALID] !== 1'b0) begin n_err++; $display("FAIL m0_rxv_clear got %b want 0", v[ST_RX_VALID]); end
        loop = 1'b0;
    endtask

    task automatic test_mode3();
        int p0, n; logic [31:0] v;
        set_ctrl(8'd3, 1'b1, 1'b1);
        n_cmp++; if (sck !== 1'b1) begin n_err++; $display("FAIL m3_idle_sck got %b want 1", sck); end
        slave_byte = 8'h3C;
        start_xfer(8'h69, p0);
        wait_done(n);
        n_cmp++; if (n != 64) begin n_err++; $display("FAIL m3_busy got %0d want 64", n); end
        n_cmp++; if (first_edge_cyc - p0 != 4) begin n_err++; $display("FAIL m3_half_period got %0d want 4", first_edge_cyc - p0); end
        n_cmp++; if (rec_mosi !== 8'h69) begin n_err++; $display("FAIL m3_mosi got %h want 69", rec_mosi); end
        n_cmp++; if (sck !== 1'b1) begin n_err++; $display("FAIL m3_end_sck got %b want 1", sck); end
        bus_read(SPI_DATA, v);
        n_cmp++; if (v !== 32'h3C) begin n_err++; $display("FAIL m3_rx got %h want 3c", v); end
    endtask

    task automatic test_random();
        int p0, n, exp_n; logic [31:0] v; logic [7:0] d, tx, sb; logic pol, pha;
        for (int t = 0; t < 8; t++) begin
            d = 8'($urandom_range(0, 3)); pol = 1'($urandom); pha = 1'($urandom);
            tx = 8'($urandom); sb = 8'($urandom);
            exp_n = 16 * (int'(d) + 1);
            set_ctrl(d, pol, pha);
            slave_byte = sb;
            start_xfer(tx, p0);
            wait_done(n);
            n_cmp++; if (n != exp_n) begin n_err++; $display("FAIL rnd%0d_busy got %0d want %0d", t, n, exp_n); end
            n_cmp++; if (edges != 16) begin n_err++; $display("FAIL rnd%0d_edges got %0d want 16", t, edges); end
            n_cmp++; if (last_edge_cyc - p0 != exp_n) begin n_err++; $display("FAIL rnd%0d_timing got %0d want %0d", t, last_edge_cyc - p0, exp_n); end
            n_cmp++; if (rec_mosi !== tx) begin n_err++; $display("FAIL rnd%0d_mosi got %h want %h", t, rec_mosi, tx); end
            n_cmp++; if (mosi !== tx[0]) begin n_err++; $display("FAIL rnd%0d_mosi_hold got %b want %b", t, mosi, tx[0]); end
            n_cmp++; if (sck !== pol) begin n_err++; $display("FAIL rnd%0d_sck_end got %b want %b", t, sck, pol); end
            bus_read(SPI_DATA, v);
            n_cmp++; if (v !== {24'd0, sb}) begin n_err++; $display("FAIL rnd%0d_rx got %h want %h", t, v, sb); end
        end
    endtask

    task automatic test_collision();
        int p0, n; logic [31:0] v;
        set_ctrl(8'd1, 1'b0, 1'b0);
        slave_byte = 8'h81;
        start_xfer(8'h11, p0);
        bus_write(SPI_DATA, 32'h22);
        wait_done(n);
        n_cmp++; if (n != 30) begin n_err++; $display("FAIL coll_busy got %0d want 30", n); end
        n_cmp++; if (rec_mosi !== 8'h11) begin n_err++; $display("FAIL coll_tx got %h want 11", rec_mosi); end
        bus_read(SPI_STATUS, v);
        n_cmp++; if (v[ST_COLL] !== 1'b1) begin n_err++; $display("FAIL coll_set got %b want 1", v[ST_COLL]); end
        bus_read(SPI_DATA, v);
        n_cmp++; if (v !== 32'h81) begin n_err++; $display("FAIL coll_rx got %h want 81", v); end
        bus_write(SPI_STATUS, 32'h4);
        bus_read(SPI_STATUS, v);
        n_cmp++; if (v[ST_COLL] !== 1'b0) begin n_err++; $display("FAIL coll_clear got %b want 0", v[ST_COLL]); end
    endtask

    task automatic test_ctrl_busy_cs();
        int p0, n; logic [31:0] v;
        set_ctrl(8'd1, 1'b0, 1'b0);
        slave_byte = 8'h4B;
        start_xfer(8'hD2, p0);
        bus_write(SPI_CTRL, {22'd0, 1'b1, 1'b1, 8'd5});
        bus_write(SPI_CS, 32'd0);
        n_cmp++; if (cs_n !== 1'b0) begin n_err++; $display("FAIL cs_low got %b want 0", cs_n); end
        bus_write(SPI_CS, 32'd1);
        n_cmp++; if (cs_n !== 1'b1) begin n_err++; $display("FAIL cs_high got %b want 1", cs_n); end
        wait_done(n);
        n_cmp++; if (n != 26) begin n_err++; $display("FAIL ctrlb_busy got %0d want 26", n); end
        n_cmp++; if (last_edge_cyc - p0 != 32) begin n_err++; $display("FAIL ctrlb_timing got %0d want 32", last_edge_cyc - p0); end
        n_cmp++; if (rec_mosi !== 8'hD2) begin n_err++; $display("FAIL ctrlb_mosi got %h want d2", rec_mosi); end
        bus_read(SPI_CTRL, v);
        n_cmp++; if (v !== 32'd1) begin n_err++; $display("FAIL ctrlb_ctrl got %h want 1", v); end
        bus_read(SPI_DATA, v);
        n_cmp++; if (v !== 32'h4B) begin n_err++; $display("FAIL ctrlb_rx got %h want 4b", v); end
    endtask

    task automatic test_read_at_done();
        int p0, n; logic [31:0] v;
        set_ctrl(8'd0, 1'b0, 1'b0);
        slave_byte = 8'h5A;
        start_xfer(8'h00, p0);
        wait_done(n);
        slave_byte = 8'hC3;
        start_xfer(8'h0F, p0);
        repeat (14) @(negedge clk);
        bus_read(SPI_DATA, v);
        n_cmp++; if (v !== 32'h5A) begin n_err++; $display("FAIL rdone_old got %h want 5a", v); end
        bus_read(SPI_STATUS, v);
        n_cmp++; if (v !== 32'h2) begin n_err++; $display("FAIL rdone_status got %h want 2", v); end
        bus_read(SPI_DATA, v);
        n_cmp++; if (v !== 32'hC3) begin n_err++; $display("FAIL rdone_new got %h want c3", v); end
    endtask

    task automatic test_reset_mid();
        int p0, n; logic [31:0] v;
        set_ctrl(8'd0, 1'b1, 1'b0);
        bus_write(SPI_CS, 32'd0);
        slave_byte = 8'h77;
        start_xfer(8'h00, p0);
        wait_done(n);
        start_xfer(8'h96, p0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (sck !== 1'b0) begin n_err++; $display("FAIL rmid_sck got %b want 0", sck); end
        n_cmp++; if (cs_n !== 1'b1) begin n_err++; $display("FAIL rmid_cs_n got %b want 1", cs_n); end
        n_cmp++; if (mosi !== 1'b0) begin n_err++; $display("FAIL rmid_mosi got %b want 0", mosi); end
        bus_read(SPI_STATUS, v);
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL rmid_status got %h want 0", v); end
        bus_read(SPI_CTRL, v);
        n_cmp++; if (v !== 32'd2) begin n_err++; $display("FAIL rmid_ctrl got %h want 2", v); end
        bus_read(SPI_DATA, v);
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL rmid_data got %h want 0", v); end
        rst_n = 1'b1;
        cfg_cpha = 1'b0; cfg_cpol = 1'b0;
        repeat (2) @(negedge clk);
        slave_byte = 8'hE1;
        start_xfer(8'h3B, p0);
        wait_done(n);
        n_cmp++; if (n != 48) begin n_err++; $display("FAIL rmid_after_busy got %0d want 48", n); end
        bus_read(SPI_DATA, v);
        n_cmp++; if (v !== 32'hE1) begin n_err++; $display("FAIL rmid_after_rx got %h want e1", v); end
    endtask

    task automatic test_sel_zero();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sel = 1'b0; rd = 1'($urandom); addr = $urandom;
            #1;
            n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL nosel_data got %h want 0", rdata); end
            n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL nosel_ready got %b want 0", ready); end
        end
        rd = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; rd = 1'b0; wmask = 4'h0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_mode0_loop();
        test_mode3();
        test_random();
        test_collision();
        test_ctrl_busy_cs();
        test_read_at_done();
        test_sel_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
